// File: rtl/rotor_ftob_step_pipe_pkg.sv
// Shared types, constants and rotor difference tables for the forward rotor path.
package rotor_ftob_step_pipe_pkg;

  localparam int ALPHA_SIZE     = 64;
  localparam int SYM_W          = 6;
  localparam int NOTCH0_DEFAULT = 16;
  localparam int NOTCH1_DEFAULT = 4;

  // Test-table differences: every entry of rotor k adds k+1.
  localparam logic [SYM_W-1:0] TEST_DIFF0 = 6'd1;
  localparam logic [SYM_W-1:0] TEST_DIFF1 = 6'd2;
  localparam logic [SYM_W-1:0] TEST_DIFF2 = 6'd3;

  typedef logic [SYM_W-1:0] sym_t;

  // Position snapshot that travels with each symbol.
  typedef struct packed {
    sym_t p0;
    sym_t p1;
    sym_t p2;
  } snap_t;

  // Difference table lookup DIFFk[idx]. Production wiring is W(x) = a*(x^m)+b,
  // a bijection because a is odd, stored as the difference W(x)-x so the
  // forward map in + DIFF[in+pos] stays a permutation for every position.
  function automatic sym_t diff_entry(input int rotor, input logic test_tables,
                                      input sym_t idx);
    sym_t d;
    case (rotor)
      0:       d = test_tables ? TEST_DIFF0 : ((idx ^ 6'h2A) * 6'd5  + 6'd17) - idx;
      1:       d = test_tables ? TEST_DIFF1 : ((idx ^ 6'h15) * 6'd11 + 6'd42) - idx;
      default: d = test_tables ? TEST_DIFF2 : ((idx ^ 6'h33) * 6'd19 + 6'd7)  - idx;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rotor_ftob_step_pipe_if.sv
// Symbol stream interface: input side and output side valid/ready handshakes.
interface rotor_ftob_step_pipe_if;
  import rotor_ftob_step_pipe_pkg::*;

  logic in_valid;
  logic in_ready;
  sym_t data_in;
  logic out_valid;
  logic out_ready;
  sym_t data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/rotor_ftob_step_pipe_rotor_fwd_stage.sv
// One forward rotor: combinational map using this symbol's own snapshot
// position, followed by the stage's valid, symbol and snapshot registers.
module rotor_fwd_stage
  import rotor_ftob_step_pipe_pkg::*;
#(
  parameter int ROTOR      = 0,
  parameter int WIRING_SEL = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  src_vld,
  input  sym_t  src_sym,
  input  snap_t src_snap,
  output logic  vld,
  output sym_t  sym,
  output snap_t snap
);

  sym_t pos;
  sym_t idx;
  sym_t mapped;

  // Forward map: out = in + DIFFk[(in + posk) mod 64].
  always_comb begin
    if (ROTOR == 0)      pos = src_snap.p0;
    else if (ROTOR == 1) pos = src_snap.p1;
    else                 pos = src_snap.p2;
    idx    = src_sym + pos;
    mapped = src_sym + diff_entry(ROTOR, WIRING_SEL != 0, idx);
  end

  // Stage registers advance together with the rest of the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      sym  <= '0;
      snap <= '0;
    end else if (en) begin
      vld  <= src_vld;
      sym  <= mapped;
      snap <= src_snap;
    end
  end

endmodule

// File: rtl/rotor_ftob_step_pipe.sv
// Forward rotor path (rotor0 -> rotor1 -> rotor2) with odometer stepping,
// position ownership and a three-stage valid/ready pipeline.
module rotor_ftob_step_pipe
  import rotor_ftob_step_pipe_pkg::*;
#(
  parameter int NOTCH0     = NOTCH0_DEFAULT,
  parameter int NOTCH1     = NOTCH1_DEFAULT,
  parameter int WIRING_SEL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_pos,
  input  sym_t r0_init,
  input  sym_t r1_init,
  input  sym_t r2_init,
  rotor_ftob_step_pipe_if.slave bus,
  output sym_t r0_position,
  output sym_t r1_position,
  output sym_t r2_position
);

  logic  adv;
  logic  accept;
  logic  c1;
  logic  c2;
  sym_t  p0n;
  sym_t  p1n;
  sym_t  p2n;
  snap_t snap_acc;

  logic  vld_p0, vld_p1, vld_p2;
  sym_t  sym_p0, sym_p1, sym_p2;
  snap_t snap_p0, snap_p1, snap_unused_p2;

  // A single advance enable keeps the three stages in lockstep; a stalled
  // output freezes the whole pipe, which also blocks new input.
  assign adv          = ~vld_p2 | bus.out_ready;
  assign bus.in_ready = adv & ~load_pos;
  assign accept       = bus.in_valid & adv & ~load_pos;

  // Odometer step: rotor1 carries only when rotor0 leaves its notch, rotor2
  // only when that carry meets rotor1 at its notch (no double-step).
  assign c1  = (r0_position == NOTCH0[SYM_W-1:0]);
  assign c2  = c1 & (r1_position == NOTCH1[SYM_W-1:0]);
  assign p0n = r0_position + 6'd1;
  assign p1n = r1_position + {5'd0, c1};
  assign p2n = r2_position + {5'd0, c2};

  // The accepted symbol is enciphered with the already-stepped positions.
  assign snap_acc = '{p0: p0n, p1: p1n, p2: p2n};

  // Position registers: load wins (it also blocks accept), else step on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_position <= '0;
      r1_position <= '0;
      r2_position <= '0;
    end else if (load_pos) begin
      r0_position <= r0_init;
      r1_position <= r1_init;
      r2_position <= r2_init;
    end else if (accept) begin
      r0_position <= p0n;
      r1_position <= p1n;
      r2_position <= p2n;
    end
  end

  // ---- stage 1: rotor0 ----
  rotor_fwd_stage #(.ROTOR(0), .WIRING_SEL(WIRING_SEL)) u_rotor0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .src_vld  (accept),
    .src_sym  (bus.data_in),
    .src_snap (snap_acc),
    .vld      (vld_p0),
    .sym      (sym_p0),
    .snap     (snap_p0)
  );

  // ---- stage 2: rotor1 ----
  rotor_fwd_stage #(.ROTOR(1), .WIRING_SEL(WIRING_SEL)) u_rotor1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .src_vld  (vld_p0),
    .src_sym  (sym_p0),
    .src_snap (snap_p0),
    .vld      (vld_p1),
    .sym      (sym_p1),
    .snap     (snap_p1)
  );

  // ---- stage 3: rotor2, feeds the reflector ----
  rotor_fwd_stage #(.ROTOR(2), .WIRING_SEL(WIRING_SEL)) u_rotor2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .src_vld  (vld_p1),
    .src_sym  (sym_p1),
    .src_snap (snap_p1),
    .vld      (vld_p2),
    .sym      (sym_p2),
    .snap     (snap_unused_p2)
  );

  assign bus.out_valid = vld_p2;
  assign bus.data_out  = sym_p2;

endmodule

// File: tb/tb_rotor_ftob_step_pipe.sv
// Directed bench for rotor_ftob_step_pipe: test-table timing/stepping checks
// and a production-table round trip through a bench-side backward path.
module tb_rotor_ftob_step_pipe;
  import rotor_ftob_step_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_pos = 1'b0;
  sym_t r0_init = '0, r1_init = '0, r2_init = '0;
  sym_t r0_pos, r1_pos, r2_pos;
  sym_t q0_pos, q1_pos, q2_pos;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] m0, m1, m2;

  rotor_ftob_step_pipe_if bus ();
  rotor_ftob_step_pipe_if bus_p ();

  always #5 clk = ~clk;

  rotor_ftob_step_pipe #(.NOTCH0(16), .NOTCH1(4), .WIRING_SEL(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_pos    (load_pos),
    .r0_init     (r0_init),
    .r1_init     (r1_init),
    .r2_init     (r2_init),
    .bus         (bus),
    .r0_position (r0_pos),
    .r1_position (r1_pos),
    .r2_position (r2_pos)
  );

  rotor_ftob_step_pipe #(.NOTCH0(16), .NOTCH1(4), .WIRING_SEL(0)) dut_p (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_pos    (load_pos),
    .r0_init     (r0_init),
    .r1_init     (r1_init),
    .r2_init     (r2_init),
    .bus         (bus_p),
    .r0_position (q0_pos),
    .r1_position (q1_pos),
    .r2_position (q2_pos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] c);
    check({tag, "_r0"}, r0_pos, a);
    check({tag, "_r1"}, r1_pos, b);
    check({tag, "_r2"}, r2_pos, c);
  endtask

  // Called at a negedge; leaves the bench at the negedge after the load edge.
  task automatic load(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    load_pos = 1'b1;
    r0_init = a; r1_init = b; r2_init = c;
    @(posedge clk);
    @(negedge clk);
    load_pos = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_one(input logic prod, input logic [5:0] s);
    if (prod) begin
      bus_p.in_valid = 1'b1; bus_p.data_in = s;
      #1 check("send_ready_p", bus_p.in_ready, 1);
    end else begin
      bus.in_valid = 1'b1; bus.data_in = s;
      #1 check("send_ready", bus.in_ready, 1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus_p.in_valid = 1'b0;
  endtask

  task automatic model_step();
    logic k1, k2;
    k1 = (m0 == 6'd16);
    k2 = k1 && (m1 == 6'd4);
    m0 = m0 + 6'd1;
    if (k1) m1 = m1 + 6'd1;
    if (k2) m2 = m2 + 6'd1;
  endtask

  // Backward pass through production rotor k by searching the forward wiring.
  function automatic logic [5:0] inv_rotor(input int k, input logic [5:0] pos,
                                           input logic [5:0] y);
    logic [5:0] t, r, xs;
    t = y + pos;
    r = '0;
    for (int x = 0; x < 64; x++) begin
      xs = x[5:0];
      if (6'(xs + diff_entry(k, 1'b0, xs)) == t) r = xs - pos;
    end
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_sym, exp_out, stall_acc, n;
    logic [5:0] got, rt;
    logic [5:0] set0 [4];
    logic [5:0] set1 [4];
    logic [5:0] set2 [4];
    set0 = '{6'd0, 6'd16, 6'd10, 6'd63};
    set1 = '{6'd0, 6'd4,  6'd3,  6'd63};
    set2 = '{6'd0, 6'd63, 6'd7,  6'd63};

    bus.in_valid = 1'b0;   bus.data_in = '0;   bus.out_ready = 1'b1;
    bus_p.in_valid = 1'b0; bus_p.data_in = '0; bus_p.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check_pos("rst_pos", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single symbol, latency and value: 5 + 1 + 2 + 3 = 11
    send_one(1'b0, 6'd5);
    check_pos("t1_pos", 1, 0, 0);
    check("t1_lat1", bus.out_valid, 0);
    @(negedge clk);
    check("t1_lat2", bus.out_valid, 0);
    @(negedge clk);
    check("t1_lat3", bus.out_valid, 1);
    check("t1_data", bus.data_out, 11);
    @(negedge clk);
    check("t1_drained", bus.out_valid, 0);

    // Notch carry and the no-carry neighbour
    load(6'd16, 6'd4, 6'd63);
    check_pos("t2_load", 16, 4, 63);
    send_one(1'b0, 6'd0);
    check_pos("t2_carry", 17, 5, 0);
    repeat (4) @(negedge clk);
    load(6'd15, 6'd4, 6'd0);
    send_one(1'b0, 6'd0);
    check_pos("t2_nocarry", 16, 4, 0);
    repeat (4) @(negedge clk);

    // Back-to-back stream 0..9 -> 6..15 on consecutive cycles
    load(6'd0, 6'd0, 6'd0);
    for (int k = 0; k < 13; k++) begin
      if (k >= 3) begin
        check("t3_valid", bus.out_valid, 1);
        check("t3_data", bus.data_out, k + 3);
      end else begin
        check("t3_idle", bus.out_valid, 0);
      end
      if (k < 10) begin
        bus.in_valid = 1'b1; bus.data_in = 6'(k);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("t3_r0_pos", r0_pos, 10);
    repeat (3) @(negedge clk);

    // Backpressure: fill, hold stable, load during stall, then drain in order
    next_sym = 0; exp_out = 6; stall_acc = 0;
    for (int k = 0; k < 20; k++) begin
      bus.out_ready = (k >= 8);
      load_pos = (k == 5);
      if (k == 5) begin r0_init = 6'd9; r1_init = 6'd9; r2_init = 6'd9; end
      bus.in_valid = (next_sym < 6);
      bus.data_in  = 6'(next_sym);
      #1;
      if (k == 6) check_pos("t4_stall_load", 9, 9, 9);
      if (k == 4) check("t4_full_ready", bus.in_ready, 0);
      if (bus.out_valid) begin
        check("t4_order", bus.data_out, exp_out);
        if (bus.out_ready) exp_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        next_sym++;
        if (k < 8) stall_acc++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; load_pos = 1'b0;
    check("t4_stall_accepts", stall_acc, 3);
    check("t4_out_count", exp_out, 12);
    check("t4_in_count", next_sym, 6);
    repeat (4) @(negedge clk);

    // Load and in_valid in the same cycle
    load_pos = 1'b1;
    r0_init = 6'd20; r1_init = 6'd30; r2_init = 6'd40;
    bus.in_valid = 1'b1; bus.data_in = 6'd7;
    #1 check("t5_ready_on_load", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    load_pos = 1'b0;
    check_pos("t5_loaded", 20, 30, 40);
    #1 check("t5_ready_after", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_pos("t5_stepped", 21, 30, 40);
    check("t5_lat1", bus.out_valid, 0);
    @(negedge clk);
    check("t5_lat2", bus.out_valid, 0);
    @(negedge clk);
    check("t5_lat3", bus.out_valid, 1);
    check("t5_data", bus.data_out, 13);
    @(negedge clk);
    check("t5_single", bus.out_valid, 0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.data_in = 6'(k);
      @(negedge clk);
    end
    check("t6_busy", bus.out_valid, 1);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_data_out", bus.data_out, 0);
    check_pos("t6_pos", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_stays_idle", bus.out_valid, 0);

    // Production tables: forward then backward with the same snapshot
    for (int si = 0; si < 4; si++) begin
      load(set0[si], set1[si], set2[si]);
      m0 = set0[si]; m1 = set1[si]; m2 = set2[si];
      for (int s = 0; s < 64; s++) begin
        send_one(1'b1, 6'(s));
        model_step();
        n = 1;
        while (!bus_p.out_valid && n < 8) begin
          @(negedge clk);
          n++;
        end
        check("t7_latency", n, 3);
        got = bus_p.data_out;
        rt = inv_rotor(0, m0, inv_rotor(1, m1, inv_rotor(2, m2, got)));
        check("t7_roundtrip", rt, s);
      end
      check("t7_q0", q0_pos, m0);
      check("t7_q1", q1_pos, m1);
      check("t7_q2", q2_pos, m2);
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor_ftob_step_pipe.md
Name: rotor_ftob_step_pipe

Overview:
- Forward (entry-to-reflector) rotor path: each accepted 6-bit symbol passes through rotor0, then rotor1, then rotor2.
- Owns the three rotor positions and steps them odometer-style once per accepted symbol, before encipherment.
- Three-stage registered pipeline, one rotor per stage, valid/ready on both sides.
- Output feeds the reflector, which feeds the existing backward (rotor2->rotor1->rotor0) path; the position outputs drive that path.

Parameters:
- NOTCH0, 16: rotor0 position at which the next step carries into rotor1.
- NOTCH1, 4: rotor1 position at which a rotor0 carry also carries into rotor2.
- WIRING_SEL, 0: 0 = production difference tables; 1 = test tables (every DIFF0 = 1, DIFF1 = 2, DIFF2 = 3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_pos  in  1  load r0_init/r1_init/r2_init into the position registers
- r0_init  in  6  rotor0 load value
- r1_init  in  6  rotor1 load value
- r2_init  in  6  rotor2 load value
- in_valid  in  1  data_in valid
- in_ready  out  1  block accepts data_in this cycle
- data_in  in  6  plaintext symbol, 0..63
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts data_out
- data_out  out  6  symbol after rotor2
- r0_position  out  6  current rotor0 position register
- r1_position  out  6  current rotor1 position register
- r2_position  out  6  current rotor2 position register

Behaviour:
- Reset (async assert, sync release): positions = 0; all stage valids = 0; out_valid = 0; data_out = 0.
- Pipeline advance: adv = ~out_valid | out_ready. Stall freezes all three stages together.
- Ready: in_ready = adv & ~load_pos. Accept = in_valid & in_ready.
- Stepping on accept, all arithmetic mod 64:
  - p0n = p0+1.
  - c1 = (p0 == NOTCH0). p1n = p1 + c1.
  - c2 = c1 & (p1 == NOTCH1). p2n = p2 + c2.
  - Registers take p0n/p1n/p2n. No double-step.
  - Wrap: 63 -> 0 with no extra carry beyond the notch rule.
- Snapshot: the accepted symbol is tagged with (p0n, p1n, p2n) and carries that snapshot down the pipe.
- Rotor k forward map: out = (in + DIFFk[(in + posk) mod 64]) mod 64, using that symbol's snapshot posk.
- Stage timing:
  - Stage1 registers the rotor0 result on accept.
  - Stage2 registers the rotor1 result.
  - Stage3 registers the rotor2 result, which is data_out.
- Latency: 3 clk from accept to out_valid when unstalled. Throughput: 1 symbol per clk.
- Bubbles propagate when adv = 1 and in_valid = 0.
- Load:
  - When load_pos = 1, positions take the init values next edge and no symbol is accepted that cycle.
  - In-flight symbols keep their snapshots.
  - Load during a stall is still applied.
- Full condition: all stages valid and out_ready = 0 -> in_ready = 0; data held stable; no loss, no duplication, order preserved.
- out_valid/data_out must stay stable while out_valid = 1 and out_ready = 0.
- Reset mid-operation: in-flight symbols are discarded immediately; positions return to 0.

Decomposition:
- Shared package: 6-bit symbol/position type; alphabet size 64; DIFF0/DIFF1/DIFF2 production tables and the test tables; default notch constants.
- One sub-module: rotor_fwd_stage (combinational forward map plus output/snapshot/valid registers with enable), instantiated three times with the rotor index as a parameter.
- Stepping logic and handshake stay in the top level.

Test Plan:
- WIRING_SEL=1, reset, in_valid with data_in=5, out_ready=1 -> out_valid=1 exactly 3 clk after accept, data_out=11; positions (1,0,0).
- load_pos with (16,4,63), then one symbol -> positions (17,5,0). Load (15,4,0) then one symbol -> positions (16,4,0), no carry.
- Stream 0..9 back-to-back with out_ready=1 -> outputs 6..15 on 10 consecutive cycles; r0_position = 10.
- out_ready=0 while streaming -> in_ready drops after 3 accepts. Raise out_ready -> outputs 6,7,8,... in order, no loss or duplicate, data stable during stall.
- load_pos=1 and in_valid=1 in the same cycle -> in_ready=0, symbol not accepted, positions equal init values. Next cycle the symbol is accepted with init+1.
- rst_n low mid-stream (async, between edges) -> out_valid=0 and positions (0,0,0) immediately.
- Production tables: route data_out through reflector bypass into the backward path using the same snapshot positions -> original data_in for all 64 symbols at 4 position sets.
